// File: rtl/program_loader_pkg.sv
// Shared definitions for the serial program loader: FSM states and word geometry.
package program_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    BYTES,
    WRITE,
    DONE,
    ERROR
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int ADDR_STEP      = 4;

  // Byte address of a program word.
  function automatic logic [31:0] word_addr(input int unsigned idx);
    return 32'(idx * ADDR_STEP);
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Host-side bundle of the program loader: byte stream in, memory write port
// and processor control out.
interface program_loader_if;

  logic        Start;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        ByteReady;
  logic        MemWrite;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic        CPUReset;
  logic        Done;
  logic        Error;

  modport master (
    output Start, ByteIn, ByteValid,
    input  ByteReady, MemWrite, MemAddress, MemWriteData, CPUReset, Done, Error
  );

  modport slave (
    input  Start, ByteIn, ByteValid,
    output ByteReady, MemWrite, MemAddress, MemWriteData, CPUReset, Done, Error
  );

endinterface

// File: rtl/program_loader_word_assembler.sv
// Big-endian byte-to-word shift register with a 2-bit byte counter; flags the
// transfer that completes a word.
module word_assembler
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        complete_o
);

  logic [31:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (shift_i) begin
      shift_d = {shift_q[23:0], byte_i};
      cnt_d   = cnt_q + 2'd1;
    end
  end

  // NOTE: the shift register is a plain 32-bit register, not a memory array,
  // so it is cleared on reset along with the counter; MemWriteData must read 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign word_o     = shift_q;
  assign complete_o = shift_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Serial program loader: reads a word-count header and big-endian instruction
// bytes, writes them to program memory and then releases the processor reset.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int MEMORY_DEPTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  program_loader_if.slave  bus
);

  localparam int IDX_W = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

  state_e           state_q, state_d;
  logic [7:0]       n_q, n_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      addr_q, addr_d;

  logic        handshake;
  logic        asm_clear;
  logic        asm_shift;
  logic        word_done;
  logic [31:0] asm_word;

  assign bus.ByteReady = (state_q == HEADER) || (state_q == BYTES);
  assign handshake     = bus.ByteValid && bus.ByteReady;
  assign asm_shift     = handshake && (state_q == BYTES);

  word_assembler u_word_assembler (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (asm_clear),
    .shift_i    (asm_shift),
    .byte_i     (bus.ByteIn),
    .word_o     (asm_word),
    .complete_o (word_done)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    asm_clear = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.Start) state_d = HEADER;
      end
      HEADER: begin
        if (handshake) begin
          n_d = bus.ByteIn;
          if (bus.ByteIn == 8'd0 || 32'(bus.ByteIn) > MEMORY_DEPTH) begin
            state_d = ERROR;
          end else begin
            state_d   = BYTES;
            idx_d     = '0;
            asm_clear = 1'b1;
          end
        end
      end
      BYTES: begin
        if (word_done) begin
          state_d = WRITE;
          addr_d  = word_addr(32'(idx_q));
        end
      end
      WRITE: begin
        if (32'(idx_q) + 32'd1 == 32'(n_q)) begin
          state_d = DONE;
        end else begin
          state_d   = BYTES;
          idx_d     = idx_q + 1'b1;
          asm_clear = 1'b1;
        end
      end
      DONE, ERROR: begin
        if (bus.Start) state_d = HEADER;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
    end
  end

  // Address and data are registered, so they hold their last values after WRITE.
  assign bus.MemWrite     = (state_q == WRITE);
  assign bus.MemAddress   = addr_q;
  assign bus.MemWriteData = asm_word;
  assign bus.CPUReset     = (state_q == DONE);
  assign bus.Done         = (state_q == DONE);
  assign bus.Error        = (state_q == ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader against a word-list model
// derived from the header count and byte stream.
module tb_program_loader;

  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic reset;

  program_loader_if bus ();

  program_loader #(.MEMORY_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          hs_count = 0;
  logic [63:0] wr_q[$];

  // Observed writes and accepted bytes, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.MemWrite === 1'b1) wr_q.push_back({bus.MemAddress, bus.MemWriteData});
    if (bus.ByteValid === 1'b1 && bus.ByteReady === 1'b1) hs_count++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (required finish)");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall);
    bus.ByteValid = 1'b0;
    repeat (stall) tick();
    bus.ByteIn    = b;
    bus.ByteValid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (bus.ByteReady === 1'b1) begin
        tick();
        return;
      end
      tick();
    end
    n_checks++;
    n_fail++;
    $display("FAIL send_byte: ByteReady stuck low for byte %02h (required 1)", b);
  endtask

  // Expected write list: one entry per word, address = 4*index, big-endian data.
  function automatic void build_model(input int n, input logic [7:0] data[$],
                                      output logic [63:0] exp[$]);
    logic [31:0] word;
    exp.delete();
    if (n >= 1 && n <= DEPTH) begin
      for (int w = 0; w < n; w++) begin
        word = 32'(data[4*w])   * 32'h0100_0000 + 32'(data[4*w+1]) * 32'h0001_0000
             + 32'(data[4*w+2]) * 32'h0000_0100 + 32'(data[4*w+3]);
        exp.push_back({32'(w * 4), word});
      end
    end
  endfunction

  task automatic run_load(input string name, input int n, input logic [7:0] data[$],
                          input int min_stall, input int max_stall, input bit rand_start);
    logic [63:0] exp[$];
    bit          valid;
    int          waited;
    valid = (n >= 1 && n <= DEPTH);
    build_model(n, data, exp);
    wr_q.delete();
    hs_count = 0;

    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    n_checks++;
    if ({bus.ByteReady, bus.CPUReset, bus.Done, bus.Error} !== 4'b1000) begin
      n_fail++;
      $display("FAIL %s start: {Ready,CPURst,Done,Err}=%b required 1000", name,
               {bus.ByteReady, bus.CPUReset, bus.Done, bus.Error});
    end

    send_byte(8'(n), $urandom_range(max_stall, min_stall));
    if (valid) begin
      for (int i = 0; i < data.size(); i++) begin
        bus.Start = rand_start && (i != data.size() - 1) ? 1'($urandom) : 1'b0;
        send_byte(data[i], $urandom_range(max_stall, min_stall));
      end
    end
    bus.ByteValid = 1'b0;
    bus.Start     = 1'b0;

    waited = 0;
    while (bus.Done !== 1'b1 && bus.Error !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end

    n_checks++;
    if ({bus.Done, bus.Error, bus.CPUReset, bus.ByteReady} !== (valid ? 4'b1010 : 4'b0100)) begin
      n_fail++;
      $display("FAIL %s end: {Done,Err,CPURst,Ready}=%b required %b", name,
               {bus.Done, bus.Error, bus.CPUReset, bus.ByteReady}, valid ? 4'b1010 : 4'b0100);
    end
    n_checks++;
    if (wr_q.size() !== exp.size()) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d required %0d", name, wr_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < wr_q.size(); i++) begin
      n_checks++;
      if (wr_q[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL %s write[%0d]: addr/data %h/%h required %h/%h", name, i,
                 wr_q[i][63:32], wr_q[i][31:0], exp[i][63:32], exp[i][31:0]);
      end
    end
    n_checks++;
    if (hs_count !== (valid ? 1 + 4 * n : 1)) begin
      n_fail++;
      $display("FAIL %s accepted_bytes: got %0d required %0d", name, hs_count,
               valid ? 1 + 4 * n : 1);
    end

    if (!valid) begin
      bus.ByteValid = 1'b1;
      repeat (3) tick();
      bus.ByteValid = 1'b0;
      n_checks++;
      if (hs_count !== 1 || wr_q.size() !== 0 || bus.Error !== 1'b1) begin
        n_fail++;
        $display("FAIL %s error_hold: accepted=%0d writes=%0d Error=%b required 1/0/1",
                 name, hs_count, wr_q.size(), bus.Error);
      end
    end
  endtask

  task automatic rand_bytes(input int n, output logic [7:0] d[$]);
    d.delete();
    for (int i = 0; i < 4 * n; i++) d.push_back(8'($urandom));
  endtask

  task automatic check_idle(input string name);
    n_checks++;
    if ({bus.ByteReady, bus.MemWrite, bus.CPUReset, bus.Done, bus.Error} !== 5'b0
        || bus.MemAddress !== 32'h0 || bus.MemWriteData !== 32'h0) begin
      n_fail++;
      $display("FAIL %s: {Ready,Wr,CPURst,Done,Err}=%b addr=%h data=%h required all 0", name,
               {bus.ByteReady, bus.MemWrite, bus.CPUReset, bus.Done, bus.Error},
               bus.MemAddress, bus.MemWriteData);
    end
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    bus.Start     = 1'b0;
    bus.ByteIn    = 8'h00;
    bus.ByteValid = 1'b0;
    repeat (2) tick();
    check_idle("reset_asserted");
    reset = 1'b1;
    repeat (2) tick();
    check_idle("reset_released");
  endtask

  task automatic test_basic_load();
    logic [7:0]  d[$];
    logic [63:0] pk;
    pk = 64'h2008_0005_0000_0000;
    for (int i = 0; i < 8; i++) d.push_back(pk[63-8*i -: 8]);
    run_load("basic", 2, d, 0, 0, 1'b0);
  endtask

  task automatic test_header_errors();
    logic [7:0] d[$];
    run_load("hdr_zero", 0, d, 0, 0, 1'b0);
    run_load("hdr_over", DEPTH + 1, d, 0, 0, 1'b0);
    rand_bytes(2, d);
    run_load("after_error", 2, d, 0, 1, 1'b0);
  endtask

  task automatic test_stalled_bytes();
    logic [7:0] d[$];
    rand_bytes(1, d);
    run_load("stalled", 1, d, 2, 2, 1'b0);
  endtask

  task automatic test_mid_load_reset();
    logic [7:0] d[$];
    wr_q.delete();
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    send_byte(8'd1, 0);
    send_byte(8'($urandom), 0);
    send_byte(8'($urandom), 0);
    bus.ByteValid = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_idle("mid_reset");
    tick();
    check_idle("mid_reset_idle");
    n_checks++;
    if (wr_q.size() !== 0) begin
      n_fail++;
      $display("FAIL mid_reset_writes: got %0d required 0", wr_q.size());
    end
    rand_bytes(1, d);
    run_load("post_reset", 1, d, 0, 1, 1'b0);
  endtask

  task automatic test_full_load_reload();
    logic [7:0] d[$];
    rand_bytes(DEPTH, d);
    run_load("full", DEPTH, d, 0, 1, 1'b1);
    n_checks++;
    if (wr_q.size() == 0 || wr_q[wr_q.size()-1][63:32] !== 32'h7C) begin
      n_fail++;
      $display("FAIL full_last_addr: got %h required 0000007c",
               wr_q.size() == 0 ? 32'hFFFF_FFFF : wr_q[wr_q.size()-1][63:32]);
    end
    rand_bytes(3, d);
    run_load("reload", 3, d, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] d[$];
    int         n;
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(8, 1);
      rand_bytes(n, d);
      run_load($sformatf("random%0d", it), n, d, 0, 3, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_header_errors();
    test_stalled_bytes();
    test_mid_load_reset();
    test_full_load_reload();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter: MEMORY_DEPTH, default 32, program memory capacity in 32-bit words.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-004 Port: Start  input  1  load request; honoured only in IDLE, DONE or ERROR.
REQ-005 Port: ByteIn  input  8  serial program byte.
REQ-006 Port: ByteValid  input  1  ByteIn is valid this cycle.
REQ-007 Port: ByteReady  output  1  loader accepts ByteIn this cycle.
REQ-008 Port: MemWrite  output  1  one-cycle write strobe to program memory.
REQ-009 Port: MemAddress  output  32  word-aligned byte address of the write.
REQ-010 Port: MemWriteData  output  32  assembled instruction word.
REQ-011 Port: CPUReset  output  1  active-low reset for the processor; 1 releases it.
REQ-012 Port: Done  output  1  load completed successfully.
REQ-013 Port: Error  output  1  header word count invalid.

Function
REQ-014 States: IDLE, HEADER, BYTES, WRITE, DONE, ERROR.
REQ-015 A byte is transferred only in a cycle where ByteValid=1 and ByteReady=1.
REQ-016 ByteReady is 1 in HEADER and BYTES, 0 in all other states.
REQ-017 IDLE -> HEADER when Start=1; otherwise IDLE is held.
REQ-018 In HEADER, the first transferred byte is the word count N.
REQ-019 HEADER -> ERROR when N=0 or N>MEMORY_DEPTH, otherwise HEADER -> BYTES, word index cleared to 0 and byte counter cleared to 0.
REQ-020 In BYTES, bytes are assembled big-endian: the first byte goes to [31:24] and the fourth to [7:0].
REQ-021 BYTES -> WRITE in the cycle after the fourth byte of a word is transferred.
REQ-022 In WRITE, MemWrite=1 for exactly one cycle, with MemAddress = word index * 4 and MemWriteData = the assembled word.
REQ-023 WRITE -> DONE if word index = N-1; otherwise the word index increments, the byte counter clears, and the state returns to BYTES.
REQ-024 MemWrite is 0 in every state other than WRITE. MemAddress and MemWriteData are don't-care when MemWrite=0 but hold their last values.
REQ-025 CPUReset is 1 only in DONE, so the processor is held in reset during IDLE, HEADER, BYTES, WRITE and ERROR.
REQ-026 Done=1 only in DONE; Error=1 only in ERROR.
REQ-027 DONE or ERROR -> HEADER when Start=1, which starts a reload; CPUReset drops to 0 in the same transition.
REQ-028 Start is ignored in HEADER, BYTES and WRITE.
REQ-029 ByteValid with no handshake (ByteReady=0) leaves all state unchanged; stalls of any length are permitted between bytes.
REQ-030 Word index width is clog2(MEMORY_DEPTH); the address never exceeds (MEMORY_DEPTH-1)*4.

Reset
REQ-031 When reset=0 at a clock edge: state becomes IDLE, and ByteReady, MemWrite, MemAddress, MemWriteData, CPUReset, Done and Error are all 0, and the word index, byte counter, N and the assembly register are cleared.
REQ-032 Reset takes priority over every transition, including reset asserted mid-load; a partial word is discarded and never written.

Structure
REQ-033 A shared package holds the state enumeration, BYTES_PER_WORD=4 and ADDR_STEP=4.
REQ-034 One sub-module, word_assembler, holds the byte shift register and the 2-bit byte counter, and flags word-complete.
REQ-035 The FSM, the word index and the output decode reside in program_loader.

Verification
REQ-036 Case: reset=0 for 2 cycles, then release. Required: all outputs 0, state IDLE.
REQ-037 Case: Start, then bytes 02, 20,08,00,05, 00,00,00,00 with ByteValid held 1. Required: two MemWrite pulses, at addr 0x0 data 0x20080005 and at addr 0x4 data 0x00000000; then Done=1 and CPUReset=1.
REQ-038 Case: Start, then header byte 00, and separately header byte MEMORY_DEPTH+1 (33). Required: Error=1, CPUReset=0, no MemWrite.
REQ-039 Case: N=1 with ByteValid toggling 1,0,0,1,... between bytes. Required: a single write of the correct word, with nothing accepted while ByteReady=0 or ByteValid=0.
REQ-040 Case: reset=0 after 2 of the 4 bytes of word 1. Required: IDLE with no MemWrite; a following Start with N=1 loads cleanly at addr 0x0.
REQ-041 Case: N=32 full load, then Start while in DONE. Required: the last write is at addr 0x7C, and the reload begins with CPUReset=0 on the next cycle.
